// File: rtl/e203_exu_oitf_pkg.sv
// Shared core configuration for the OITF slice: queue depth, itag width,
// register-index width and pc width. The optional per-entry pc storage is
// selected by the E203_OITF_PC_EN macro in the top module.
package e203_exu_oitf_pkg;

  localparam int E203_OITF_DEPTH  = 4;
  localparam int E203_ITAG_WIDTH  = 2;
  localparam int E203_RFIDX_WIDTH = 5;
  localparam int E203_PC_SIZE     = 32;

  // Advance a {wrap flag, index} pointer; DEPTH is a power of two, so the
  // carry out of the index naturally toggles the wrap flag.
  function automatic logic [E203_ITAG_WIDTH:0] ptr_inc(input logic [E203_ITAG_WIDTH:0] p);
    ptr_inc = p + {{E203_ITAG_WIDTH{1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/e203_exu_oitf_match.sv
// Dependency compare of one dispatching register against every OITF entry.
// An entry hits when it is valid, writes its rd, and its rd index and
// register-file select both equal the source's.
module e203_exu_oitf_match
  import e203_exu_oitf_pkg::*;
#(
  parameter int DEPTH = E203_OITF_DEPTH
) (
  input  logic [DEPTH-1:0]                  vld,
  input  logic [DEPTH-1:0]                  rdwen,
  input  logic [DEPTH*E203_RFIDX_WIDTH-1:0] rdidx,
  input  logic [DEPTH-1:0]                  rdfpu,
  input  logic                              src_en,
  input  logic [E203_RFIDX_WIDTH-1:0]       src_idx,
  input  logic                              src_fpu,
  output logic                              match
);

  // OR-reduce per-entry hits, then qualify with the source enable
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && rdwen[i] &&
          (rdidx[i*E203_RFIDX_WIDTH +: E203_RFIDX_WIDTH] == src_idx) &&
          (rdfpu[i] == src_fpu)) begin
        match = 1'b1;
      end
    end
    match = match & src_en;
  end

endmodule

// File: rtl/e203_exu_oitf.sv
// Outstanding Instruction Track FIFO. One entry per dispatched long-pipe
// instruction, retired in order on long-pipe write-back. Feeds RAW/WAW
// dependency flags, the empty flag and the next itag back to dispatch.
// Optional macro E203_OITF_PC_EN: store a pc per entry and show it on ret_pc.
//
// Handshake: an entry is allocated at a rising clk edge when dis_ena and
// dis_ready are both high (dis_ena while full is ignored); the oldest entry
// is retired when ret_ena is high and the FIFO is not empty (ret_ena while
// empty is ignored). All state-derived outputs change the cycle after.
module e203_exu_oitf
  import e203_exu_oitf_pkg::*;
#(
  parameter int DEPTH = E203_OITF_DEPTH,
  parameter int PTR_W = E203_ITAG_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dis_ena,
  output logic                        dis_ready,
  output logic [PTR_W-1:0]            dis_ptr,
  input  logic                        ret_ena,
  output logic [PTR_W-1:0]            ret_ptr,
  output logic [E203_RFIDX_WIDTH-1:0] ret_rdidx,
  output logic                        ret_rdwen,
  output logic                        ret_rdfpu,
  output logic [E203_PC_SIZE-1:0]     ret_pc,
  input  logic                        disp_i_rs1en,
  input  logic                        disp_i_rs2en,
  input  logic                        disp_i_rs3en,
  input  logic                        disp_i_rdwen,
  input  logic                        disp_i_rs1fpu,
  input  logic                        disp_i_rs2fpu,
  input  logic                        disp_i_rs3fpu,
  input  logic                        disp_i_rdfpu,
  input  logic [E203_RFIDX_WIDTH-1:0] disp_i_rs1idx,
  input  logic [E203_RFIDX_WIDTH-1:0] disp_i_rs2idx,
  input  logic [E203_RFIDX_WIDTH-1:0] disp_i_rs3idx,
  input  logic [E203_RFIDX_WIDTH-1:0] disp_i_rdidx,
  input  logic [E203_PC_SIZE-1:0]     disp_i_pc,
  output logic                        oitfrd_match_disprs1,
  output logic                        oitfrd_match_disprs2,
  output logic                        oitfrd_match_disprs3,
  output logic                        oitfrd_match_disprd,
  output logic                        oitf_empty
);

  localparam int RW = E203_RFIDX_WIDTH;

  logic [PTR_W:0]      alloc_q;   // {wrap flag, index}
  logic [PTR_W:0]      ret_q;
  logic [DEPTH-1:0]    vld_q;
  logic [DEPTH-1:0]    rdwen_q;
  logic [DEPTH-1:0]    rdfpu_q;
  logic [DEPTH*RW-1:0] rdidx_q;

  logic [PTR_W-1:0] alloc_idx;
  logic [PTR_W-1:0] ret_idx;
  logic             full;
  logic             alloc_go;
  logic             ret_go;

  assign alloc_idx = alloc_q[PTR_W-1:0];
  assign ret_idx   = ret_q[PTR_W-1:0];

  // Same index with opposite wrap flags means every entry is occupied
  assign full       = (alloc_idx == ret_idx) && (alloc_q[PTR_W] != ret_q[PTR_W]);
  assign oitf_empty = (alloc_q == ret_q);
  assign dis_ready  = ~full;
  assign alloc_go   = dis_ena & ~full;
  assign ret_go     = ret_ena & ~oitf_empty;

  assign dis_ptr   = alloc_idx;
  assign ret_ptr   = ret_idx;
  assign ret_rdidx = rdidx_q[ret_idx*RW +: RW];
  assign ret_rdwen = rdwen_q[ret_idx];
  assign ret_rdfpu = rdfpu_q[ret_idx];

  // Alloc and retire pointers advance independently with wrap-flag toggle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_q <= '0;
      ret_q   <= '0;
    end else begin
      if (alloc_go) alloc_q <= ptr_inc(alloc_q);
      if (ret_go)   ret_q   <= ptr_inc(ret_q);
    end
  end

  // Valid bits: set on alloc, cleared on retire (never the same slot in one cycle)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      if (ret_go)   vld_q[ret_idx]   <= 1'b0;
      if (alloc_go) vld_q[alloc_idx] <= 1'b1;
    end
  end

  // Capture destination-register fields of the allocated instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdwen_q <= '0;
      rdfpu_q <= '0;
      rdidx_q <= '0;
    end else if (alloc_go) begin
      rdwen_q[alloc_idx]          <= disp_i_rdwen;
      rdfpu_q[alloc_idx]          <= disp_i_rdfpu;
      rdidx_q[alloc_idx*RW +: RW] <= disp_i_rdidx;
    end
  end

`ifdef E203_OITF_PC_EN
  logic [E203_PC_SIZE-1:0] pc_q [DEPTH];

  // Per-entry pc, reported for the oldest entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pc_q[i] <= '0;
    end else if (alloc_go) begin
      pc_q[alloc_idx] <= disp_i_pc;
    end
  end

  assign ret_pc = pc_q[ret_idx];
`else
  logic unused_pc;

  assign unused_pc = ^disp_i_pc;
  assign ret_pc    = '0;
`endif

  // Entries being retired this cycle still count toward a match (conservative)
  e203_exu_oitf_match #(.DEPTH(DEPTH)) u_match_rs1 (
    .vld(vld_q), .rdwen(rdwen_q), .rdidx(rdidx_q), .rdfpu(rdfpu_q),
    .src_en(disp_i_rs1en), .src_idx(disp_i_rs1idx), .src_fpu(disp_i_rs1fpu),
    .match(oitfrd_match_disprs1)
  );

  e203_exu_oitf_match #(.DEPTH(DEPTH)) u_match_rs2 (
    .vld(vld_q), .rdwen(rdwen_q), .rdidx(rdidx_q), .rdfpu(rdfpu_q),
    .src_en(disp_i_rs2en), .src_idx(disp_i_rs2idx), .src_fpu(disp_i_rs2fpu),
    .match(oitfrd_match_disprs2)
  );

  e203_exu_oitf_match #(.DEPTH(DEPTH)) u_match_rs3 (
    .vld(vld_q), .rdwen(rdwen_q), .rdidx(rdidx_q), .rdfpu(rdfpu_q),
    .src_en(disp_i_rs3en), .src_idx(disp_i_rs3idx), .src_fpu(disp_i_rs3fpu),
    .match(oitfrd_match_disprs3)
  );

  e203_exu_oitf_match #(.DEPTH(DEPTH)) u_match_rd (
    .vld(vld_q), .rdwen(rdwen_q), .rdidx(rdidx_q), .rdfpu(rdfpu_q),
    .src_en(disp_i_rdwen), .src_idx(disp_i_rdidx), .src_fpu(disp_i_rdfpu),
    .match(oitfrd_match_disprd)
  );

endmodule

// File: tb/tb_e203_exu_oitf.sv
// Bench for e203_exu_oitf: directed scenarios plus random traffic, checked
// against an in-order queue model of outstanding instructions.
module tb_e203_exu_oitf;
  import e203_exu_oitf_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        dis_ena, dis_ready, ret_ena;
  logic [1:0]  dis_ptr, ret_ptr;
  logic [4:0]  ret_rdidx;
  logic        ret_rdwen, ret_rdfpu;
  logic [31:0] ret_pc;
  logic        disp_i_rs1en, disp_i_rs2en, disp_i_rs3en, disp_i_rdwen;
  logic        disp_i_rs1fpu, disp_i_rs2fpu, disp_i_rs3fpu, disp_i_rdfpu;
  logic [4:0]  disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx, disp_i_rdidx;
  logic [31:0] disp_i_pc;
  logic        m_rs1, m_rs2, m_rs3, m_rd, oitf_empty;

  e203_exu_oitf #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst),
    .dis_ena(dis_ena), .dis_ready(dis_ready), .dis_ptr(dis_ptr),
    .ret_ena(ret_ena), .ret_ptr(ret_ptr), .ret_rdidx(ret_rdidx),
    .ret_rdwen(ret_rdwen), .ret_rdfpu(ret_rdfpu), .ret_pc(ret_pc),
    .disp_i_rs1en(disp_i_rs1en), .disp_i_rs2en(disp_i_rs2en),
    .disp_i_rs3en(disp_i_rs3en), .disp_i_rdwen(disp_i_rdwen),
    .disp_i_rs1fpu(disp_i_rs1fpu), .disp_i_rs2fpu(disp_i_rs2fpu),
    .disp_i_rs3fpu(disp_i_rs3fpu), .disp_i_rdfpu(disp_i_rdfpu),
    .disp_i_rs1idx(disp_i_rs1idx), .disp_i_rs2idx(disp_i_rs2idx),
    .disp_i_rs3idx(disp_i_rs3idx), .disp_i_rdidx(disp_i_rdidx),
    .disp_i_pc(disp_i_pc),
    .oitfrd_match_disprs1(m_rs1), .oitfrd_match_disprs2(m_rs2),
    .oitfrd_match_disprs3(m_rs3), .oitfrd_match_disprd(m_rd),
    .oitf_empty(oitf_empty)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]  rdidx;
    logic        rdwen;
    logic        rdfpu;
    logic [31:0] pc;
  } ment_t;

  ment_t mq[$];          // outstanding instructions, oldest first
  int    alloc_tot;      // allocations since reset
  int    ret_tot;        // retirements since reset

  typedef struct packed {
    logic        care;   // oldest-entry fields are meaningful
    logic        dis_ready;
    logic [1:0]  dis_ptr;
    logic [1:0]  ret_ptr;
    logic [4:0]  ret_rdidx;
    logic        ret_rdwen;
    logic        ret_rdfpu;
    logic [31:0] ret_pc;
    logic        empty;
    logic [3:0]  match;  // {rs1, rs2, rs3, rd}
  } exp_t;

  logic [$bits(exp_t)-1:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic src_hit(input logic en, input logic [4:0] idx, input logic fpu);
    logic hit;
    hit = 1'b0;
    if (en) begin
      foreach (mq[k]) begin
        if (mq[k].rdwen && (mq[k].rdidx == idx) && (mq[k].rdfpu == fpu)) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    dis_ena = 0; ret_ena = 0;
    disp_i_rs1en = 0; disp_i_rs2en = 0; disp_i_rs3en = 0; disp_i_rdwen = 0;
    disp_i_rs1fpu = 0; disp_i_rs2fpu = 0; disp_i_rs3fpu = 0; disp_i_rdfpu = 0;
    disp_i_rs1idx = 0; disp_i_rs2idx = 0; disp_i_rs3idx = 0; disp_i_rdidx = 0;
    disp_i_pc = 0;
  endtask

  task automatic model_reset();
    mq.delete();
    alloc_tot = 0;
    ret_tot   = 0;
  endtask

  // Present current inputs for one cycle: push the expected outputs, then
  // apply the clock edge to the model.
  task automatic step();
    exp_t e;
    logic do_alloc, do_ret;
    e = '0;
    e.care      = (mq.size() > 0);
    e.dis_ready = (mq.size() < DEPTH);
    e.dis_ptr   = 2'(alloc_tot % DEPTH);
    e.ret_ptr   = 2'(ret_tot % DEPTH);
    e.empty     = (mq.size() == 0);
    if (mq.size() > 0) begin
      e.ret_rdidx = mq[0].rdidx;
      e.ret_rdwen = mq[0].rdwen;
      e.ret_rdfpu = mq[0].rdfpu;
`ifdef E203_OITF_PC_EN
      e.ret_pc    = mq[0].pc;
`endif
    end
    e.match = {src_hit(disp_i_rs1en, disp_i_rs1idx, disp_i_rs1fpu),
               src_hit(disp_i_rs2en, disp_i_rs2idx, disp_i_rs2fpu),
               src_hit(disp_i_rs3en, disp_i_rs3idx, disp_i_rs3fpu),
               src_hit(disp_i_rdwen, disp_i_rdidx,  disp_i_rdfpu)};
    exp_q.push_back(e);
    @(posedge clk);
    do_alloc = dis_ena && (mq.size() < DEPTH);
    do_ret   = ret_ena && (mq.size() > 0);
    if (do_ret) begin
      void'(mq.pop_front());
      ret_tot++;
    end
    if (do_alloc) begin
      mq.push_back(ment_t'{disp_i_rdidx, disp_i_rdwen, disp_i_rdfpu, disp_i_pc});
      alloc_tot++;
    end
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic wen, input logic fpu, input logic [31:0] pc);
    clear_inputs();
    dis_ena = 1; disp_i_rdidx = rd; disp_i_rdwen = wen; disp_i_rdfpu = fpu; disp_i_pc = pc;
    step();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("dis_ready",  dis_ready,  e.dis_ready);
      check("dis_ptr",    dis_ptr,    e.dis_ptr);
      check("ret_ptr",    ret_ptr,    e.ret_ptr);
      check("oitf_empty", oitf_empty, e.empty);
      check("match",      {m_rs1, m_rs2, m_rs3, m_rd}, e.match);
`ifndef E203_OITF_PC_EN
      check("ret_pc_tied", ret_pc, 32'h0);
`endif
      if (e.care) begin
        check("ret_rdidx", ret_rdidx, e.ret_rdidx);
        check("ret_rdwen", ret_rdwen, e.ret_rdwen);
        check("ret_rdfpu", ret_rdfpu, e.ret_rdfpu);
        check("ret_pc",    ret_pc,    e.ret_pc);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: idle after reset, ret_ena on empty is ignored, alloc+retire on empty only allocates
    step();
    ret_ena = 1; step();
    clear_inputs(); step();
    dis_ena = 1; ret_ena = 1; disp_i_rdidx = 5'd3; disp_i_rdwen = 1; disp_i_pc = 32'h40;
    step();
    clear_inputs(); step();

    // 2: RAW hit on rs1, miss on rs2
    apply_reset();
    alloc(5'd5, 1'b1, 1'b0, 32'h8000_0100);
    clear_inputs();
    disp_i_rs1en = 1; disp_i_rs1idx = 5'd5;
    disp_i_rs2en = 1; disp_i_rs2idx = 5'd6;
    step();

    // 3: fill to DEPTH, pointer wrap, extra dis_ena while full ignored
    apply_reset();
    for (int i = 0; i < DEPTH; i++) alloc(5'(i + 1), 1'b1, 1'(i & 1), 32'h1000 + 32'(i * 4));
    alloc(5'd9, 1'b1, 1'b0, 32'hdead);
    clear_inputs(); step();

    // 4: from full, dispatch (when ready) and retire every cycle
    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      dis_ena = 1; ret_ena = 1;
      disp_i_rdidx = 5'($urandom_range(0, 31)); disp_i_rdwen = 1;
      disp_i_pc = $urandom;
      step();
    end

    // 5: register-file select distinguishes otherwise equal indexes
    apply_reset();
    alloc(5'd7, 1'b1, 1'b1, 32'h2000);
    clear_inputs();
    disp_i_rdwen = 1; disp_i_rdidx = 5'd7; disp_i_rdfpu = 0; step();
    disp_i_rdfpu = 1; step();
    disp_i_rdidx = 5'd0; disp_i_rdfpu = 0; step();

    // random traffic with small index ranges to provoke hits
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      dis_ena       = 1'($urandom_range(0, 1));
      ret_ena       = (mq.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      disp_i_rdwen  = 1'($urandom_range(0, 3) != 0);
      disp_i_rdidx  = 5'($urandom_range(0, 7));
      disp_i_rdfpu  = 1'($urandom_range(0, 1));
      disp_i_pc     = $urandom;
      disp_i_rs1en  = 1'($urandom_range(0, 1));
      disp_i_rs2en  = 1'($urandom_range(0, 1));
      disp_i_rs3en  = 1'($urandom_range(0, 1));
      disp_i_rs1idx = 5'($urandom_range(0, 7));
      disp_i_rs2idx = 5'($urandom_range(0, 7));
      disp_i_rs3idx = 5'($urandom_range(0, 7));
      disp_i_rs1fpu = 1'($urandom_range(0, 1));
      disp_i_rs2fpu = 1'($urandom_range(0, 1));
      disp_i_rs3fpu = 1'($urandom_range(0, 1));
      step();
    end

    // 6: asynchronous reset with three entries in flight
    apply_reset();
    for (int i = 0; i < 3; i++) alloc(5'(10 + i), 1'b1, 1'b0, 32'h3000 + 32'(i));
    clear_inputs();
    #2 rst = 1'b1;
    #1;
    check("async_rst_empty", oitf_empty, 1'b1);
    check("async_rst_ready", dis_ready,  1'b1);
    check("async_rst_ptrs",  {dis_ptr, ret_ptr}, 4'h0);
    check("async_rst_pc",    ret_pc,     32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    alloc(5'd4, 1'b1, 1'b0, 32'h44);
    clear_inputs(); step();

    // final report
    repeat (2) @(negedge clk);
    check("scoreboard_drain", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
